// File: rtl/echo_queue_if.sv
// Echo queue handshake bundle: host request, loopback inject and indication ports.
interface echo_queue_if #(
  parameter int unsigned WIDTH = 32
);
  logic             echoReq__ENA;
  logic [WIDTH-1:0] echoReq_v;
  logic             echoReq__RDY;
  logic             inject__ENA;
  logic [WIDTH-1:0] inject_v;
  logic             inject__RDY;
  logic             ind_echo__ENA;
  logic [WIDTH-1:0] ind_echo_v;
  logic             ind_echo__RDY;

  modport slave (
    input  echoReq__ENA, echoReq_v, inject__ENA, inject_v, ind_echo__RDY,
    output echoReq__RDY, inject__RDY, ind_echo__ENA, ind_echo_v
  );

  modport master (
    output echoReq__ENA, echoReq_v, inject__ENA, inject_v, ind_echo__RDY,
    input  echoReq__RDY, inject__RDY, ind_echo__ENA, ind_echo_v
  );
endinterface

// File: rtl/echo_queue.sv
// Echo server: FIFO-buffers host/inject words and replays them, optionally
// transformed, on a backpressured indication port.
module echo_queue #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned MODE   = 0,
  parameter int unsigned ADDEND = 1
) (
  input  logic                         CLK,
  input  logic                         RST,
  echo_queue_if.slave                  bus,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [31:0]                  echo_total,
  output logic                         err,
  input  logic                         err_clr
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  logic             full_c;
  logic             empty_c;
  logic             enq_inj_c;
  logic             enq_req_c;
  logic             enq_c;
  logic             deq_c;
  logic             drop_c;
  logic [WIDTH-1:0] wdata_c;
  logic [WIDTH-1:0] head_c;
  logic [WIDTH-1:0] xform_c;

  assign full_c  = (count == CNT_W'(DEPTH));
  assign empty_c = (count == CNT_W'(0));

  // Ready flags come only from registered state (plus inject priority), held low in reset.
  assign bus.inject__RDY   = !RST && !full_c;
  assign bus.echoReq__RDY  = !RST && !full_c && !bus.inject__ENA;
  assign bus.ind_echo__ENA = !RST && !empty_c;

  assign enq_inj_c = bus.inject__ENA && bus.inject__RDY;
  assign enq_req_c = bus.echoReq__ENA && bus.echoReq__RDY;
  assign enq_c     = enq_inj_c || enq_req_c;
  assign wdata_c   = enq_inj_c ? bus.inject_v : bus.echoReq_v;
  assign deq_c     = bus.ind_echo__ENA && bus.ind_echo__RDY;
  assign drop_c    = (bus.echoReq__ENA && !bus.echoReq__RDY) ||
                     (bus.inject__ENA && !bus.inject__RDY);

  // Head-of-queue transform selected at elaboration.
  always_comb begin
    head_c = mem[rd_ptr];
    case (MODE)
      32'd1:   xform_c = head_c + WIDTH'(ADDEND);
      32'd2:   xform_c = ~head_c;
      default: xform_c = head_c;
    endcase
  end

  assign bus.ind_echo_v = bus.ind_echo__ENA ? xform_c : '0;

  // Storage array is not reset; only pointers and occupancy define validity.
  always_ff @(posedge CLK) begin
    if (enq_c) begin
      mem[wr_ptr] <= wdata_c;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      echo_total <= '0;
      err        <= 1'b0;
    end else begin
      if (enq_c) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (deq_c) begin
        rd_ptr     <= rd_ptr + PTR_W'(1);
        echo_total <= echo_total + 32'd1;
      end
      case ({enq_c, deq_c})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      // A dropped word in the same cycle as a clear keeps the flag set.
      if (drop_c) begin
        err <= 1'b1;
      end else if (err_clr) begin
        err <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_echo_queue.sv
// Scoreboard bench for echo_queue: main 32-bit identity instance plus two
// 8-bit instances exercising the add and invert transforms.
module tb_echo_queue;
  localparam int unsigned W  = 32;
  localparam int unsigned D  = 4;
  localparam int unsigned CW = $clog2(D + 1);

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  echo_queue_if #(.WIDTH(W)) q_if ();
  echo_queue_if #(.WIDTH(8)) a_if ();
  echo_queue_if #(.WIDTH(8)) n_if ();

  logic [CW-1:0] count, a_count, n_count;
  logic [31:0]   echo_total, a_total, n_total;
  logic          err, a_err, n_err;
  logic          err_clr;

  echo_queue #(.WIDTH(W), .DEPTH(D), .MODE(0), .ADDEND(1)) dut (
    .CLK(CLK), .RST(RST), .bus(q_if), .count(count),
    .echo_total(echo_total), .err(err), .err_clr(err_clr));

  echo_queue #(.WIDTH(8), .DEPTH(D), .MODE(1), .ADDEND(1)) dut_add (
    .CLK(CLK), .RST(RST), .bus(a_if), .count(a_count),
    .echo_total(a_total), .err(a_err), .err_clr(1'b0));

  echo_queue #(.WIDTH(8), .DEPTH(D), .MODE(2), .ADDEND(1)) dut_inv (
    .CLK(CLK), .RST(RST), .bus(n_if), .count(n_count),
    .echo_total(n_total), .err(n_err), .err_clr(1'b0));

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] exp_q[$];
  int          m_count;
  logic [31:0] m_total;
  logic        m_err;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock of stimulus: drive, sample #1 later, score, then advance to next negedge.
  task automatic drive(input logic inj, input logic [31:0] iv,
                       input logic req, input logic [31:0] rv,
                       input logic ordy, input logic clr);
    logic        full;
    logic        enq;
    logic        deq;
    logic [31:0] exp_v;
    q_if.inject__ENA   = inj;
    q_if.inject_v      = iv;
    q_if.echoReq__ENA  = req;
    q_if.echoReq_v     = rv;
    q_if.ind_echo__RDY = ordy;
    err_clr            = clr;
    #1;
    check("count", 64'(count), 64'(m_count));
    check("echo_total", 64'(echo_total), 64'(m_total));
    check("err", 64'(err), 64'(m_err));
    full = (m_count == D);
    check("inject_rdy", 64'(q_if.inject__RDY), 64'(!full));
    check("req_rdy", 64'(q_if.echoReq__RDY), 64'(!full && !inj));
    check("ind_ena", 64'(q_if.ind_echo__ENA), 64'(m_count != 0));
    deq = 1'b0;
    if (m_count == 0) begin
      check("ind_v_empty", 64'(q_if.ind_echo_v), 64'(0));
    end else if (ordy) begin
      exp_v = exp_q.pop_front();
      check("ind_v", 64'(q_if.ind_echo_v), 64'(exp_v));
      m_total = m_total + 32'd1;
      deq = 1'b1;
    end
    enq = 1'b0;
    if (!full && inj) begin
      exp_q.push_back(iv);
      enq = 1'b1;
    end else if (!full && req) begin
      exp_q.push_back(rv);
      enq = 1'b1;
    end
    if ((req && (full || inj)) || (inj && full)) m_err = 1'b1;
    else if (clr) m_err = 1'b0;
    m_count = m_count + int'(enq) - int'(deq);
    @(negedge CLK);
  endtask

  task automatic idle(input logic ordy);
    drive(1'b0, 32'd0, 1'b0, 32'd0, ordy, 1'b0);
  endtask

  initial begin
    RST = 1'b1;
    err_clr = 1'b0;
    q_if.inject__ENA = 1'b0; q_if.inject_v = '0; q_if.echoReq__ENA = 1'b0;
    q_if.echoReq_v = '0; q_if.ind_echo__RDY = 1'b0;
    a_if.inject__ENA = 1'b0; a_if.inject_v = '0; a_if.echoReq__ENA = 1'b0;
    a_if.echoReq_v = '0; a_if.ind_echo__RDY = 1'b1;
    n_if.inject__ENA = 1'b0; n_if.inject_v = '0; n_if.echoReq__ENA = 1'b0;
    n_if.echoReq_v = '0; n_if.ind_echo__RDY = 1'b1;
    m_count = 0; m_total = '0; m_err = 1'b0;
    repeat (2) @(negedge CLK);
    #1;
    check("rst_req_rdy", 64'(q_if.echoReq__RDY), 64'(0));
    check("rst_inj_rdy", 64'(q_if.inject__RDY), 64'(0));
    check("rst_ind_ena", 64'(q_if.ind_echo__ENA), 64'(0));
    check("rst_ind_v", 64'(q_if.ind_echo_v), 64'(0));
    check("rst_count", 64'(count), 64'(0));
    check("rst_total", 64'(echo_total), 64'(0));
    @(negedge CLK);
    RST = 1'b0;

    // Transforms on the 8-bit instances.
    a_if.echoReq__ENA = 1'b1; a_if.echoReq_v = 8'hFF;
    n_if.echoReq__ENA = 1'b1; n_if.echoReq_v = 8'h5A;
    @(negedge CLK);
    a_if.echoReq__ENA = 1'b0; n_if.echoReq__ENA = 1'b0;
    #1;
    check("add_ena", 64'(a_if.ind_echo__ENA), 64'(1));
    check("add_v", 64'(a_if.ind_echo_v), 64'(8'h00));
    check("inv_ena", 64'(n_if.ind_echo__ENA), 64'(1));
    check("inv_v", 64'(n_if.ind_echo_v), 64'(8'hA5));
    @(negedge CLK);
    #1;
    check("add_total", 64'(a_total), 64'(1));
    check("inv_count", 64'(n_count), 64'(0));
    @(negedge CLK);

    // Single echo.
    drive(1'b0, 32'd0, 1'b1, 32'h12345678, 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);
    check("single_total", 64'(echo_total), 64'(1));

    // Fill under backpressure, overflow attempt, then drain in order.
    for (int i = 1; i <= 4; i++) drive(1'b0, 32'd0, 1'b1, 32'(i), 1'b0, 1'b0);
    drive(1'b0, 32'd0, 1'b1, 32'd5, 1'b0, 1'b0);
    idle(1'b0);
    check("fill_count", 64'(count), 64'(4));
    check("fill_err", 64'(err), 64'(1));
    for (int i = 0; i < 4; i++) idle(1'b1);
    drive(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1);
    idle(1'b0);

    // Inject priority over a same-cycle host request.
    drive(1'b1, 32'd99, 1'b1, 32'd7, 1'b0, 1'b0);
    idle(1'b1);
    check("arb_err", 64'(err), 64'(1));
    drive(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1);
    idle(1'b0);

    // Full with a simultaneous dequeue still rejects the enqueue.
    for (int i = 0; i < 4; i++) drive(1'b0, 32'd0, 1'b1, 32'hA0 + 32'(i), 1'b0, 1'b0);
    drive(1'b0, 32'd0, 1'b1, 32'd8, 1'b1, 1'b0);
    idle(1'b0);
    check("fulldeq_count", 64'(count), 64'(3));
    repeat (3) idle(1'b1);
    drive(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1);

    // Full-rate stream of 10 words through the 4-deep queue.
    for (int i = 0; i < 10; i++) drive(1'b0, 32'd0, 1'b1, 32'h100 + 32'(i), 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);

    // Random mix of inject, request, backpressure and clear.
    for (int i = 0; i < 60; i++)
      drive($urandom_range(3, 0) == 0, $urandom, $urandom_range(1, 0) == 1, $urandom,
            $urandom_range(2, 0) != 0, $urandom_range(7, 0) == 0);
    while (m_count != 0) idle(1'b1);

    // Reset mid-stream discards queued words immediately.
    for (int i = 0; i < 3; i++) drive(1'b0, 32'd0, 1'b1, 32'h200 + 32'(i), 1'b0, 1'b0);
    RST = 1'b1;
    #1;
    check("midrst_count", 64'(count), 64'(0));
    check("midrst_ind_ena", 64'(q_if.ind_echo__ENA), 64'(0));
    check("midrst_req_rdy", 64'(q_if.echoReq__RDY), 64'(0));
    @(negedge CLK);
    RST = 1'b0;
    exp_q.delete();
    m_count = 0; m_total = '0; m_err = 1'b0;
    idle(1'b1);
    drive(1'b0, 32'd0, 1'b1, 32'hCAFE, 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
